// File: rtl/euler_pkg.sv
// euler_pkg: shared constants and types for the Euler solver result path.
//   RESULT_W   - binary result width (64)
//   BCD_DIGITS - decimal digits needed for RESULT_W bits (20)
//   BCD_W      - packed BCD width (80)
//   conv_state_e - conversion FSM states (IDLE, SHIFT, DONE)
//   BLANK_CODE - nibble value used for suppressed leading digits
package euler_pkg;

  localparam int RESULT_W   = 64;
  localparam int BCD_DIGITS = 20;
  localparam int BCD_W      = BCD_DIGITS * 4;
  localparam int SCRATCH_W  = BCD_W + RESULT_W;
  localparam int CNT_W      = 7;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_e;

  // Replace zero digits above the most significant non-zero digit with
  // BLANK_CODE. Digit 0 is always kept so a zero value still shows "0".
  function automatic logic [BCD_W-1:0] blank_leading(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    logic             lead;
    r    = b;
    lead = 1'b1;
    for (int i = BCD_DIGITS - 1; i >= 1; i--) begin
      if (lead && (b[i*4 +: 4] == 4'h0)) begin
        r[i*4 +: 4] = BLANK_CODE;
      end else begin
        lead = 1'b0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// bcd_dabble_step: one combinational double-dabble iteration.
//   scratch_i - {BCD field [143:64], binary field [63:0]}
//   scratch_o - scratch after add-3 correction of BCD nibbles >= 5,
//               shifted left by one bit
module bcd_dabble_step
  import euler_pkg::*;
(
  input  logic [SCRATCH_W-1:0] scratch_i,
  output logic [SCRATCH_W-1:0] scratch_o
);

  logic [SCRATCH_W-1:0] corr;

  always_comb begin
    corr = scratch_i;
    // Only the BCD field is corrected; the binary field shifts through as-is.
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (scratch_i[RESULT_W + 4*i +: 4] >= 4'd5) begin
        corr[RESULT_W + 4*i +: 4] = scratch_i[RESULT_W + 4*i +: 4] + 4'd3;
      end
    end
    scratch_o = {corr[SCRATCH_W-2:0], 1'b0};
  end

endmodule

// File: rtl/result_bcd_conv.sv
// result_bcd_conv: captures a 64-bit solver result on a rising edge of
// results_valid and converts it to 20 packed BCD digits with a sequential
// double-dabble (one iteration per enabled clock, 64 iterations).
//
// Ports:
//   clk           - clock, rising edge
//   reset         - synchronous active-high reset
//   enable        - clock enable; low freezes all state and outputs
//   results_valid - level from the solver, high while results is final
//   results       - unsigned binary value to convert
//   busy          - high while a conversion is in progress
//   bcd_valid     - high while bcd holds a completed conversion
//   bcd           - digit 0 in [3:0] .. digit 19 in [79:76]
//
// Handshake: there is no back-pressure. A conversion starts on an enabled
// edge where results_valid is high and was low on the previous enabled edge.
// Rising edges seen while a conversion runs are dropped, not queued.
//
// Build option: define RESULT_BCD_BLANK_EN to replace leading zero digits
// (except digit 0) with 4'hF when the result is loaded.
module result_bcd_conv
  import euler_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                results_valid,
  input  logic [RESULT_W-1:0] results,
  output logic                busy,
  output logic                bcd_valid,
  output logic [BCD_W-1:0]    bcd
);

  conv_state_e          state_q;
  logic                 rv_q;
  logic [SCRATCH_W-1:0] scratch_q;
  logic [SCRATCH_W-1:0] scratch_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_d;
  logic [BCD_W-1:0]     bcd_q;
  logic [BCD_W-1:0]     bcd_d;
  logic                 bcd_valid_q;
  logic                 busy_q;
  logic                 start;

  assign start = results_valid && !rv_q;
  assign cnt_d = cnt_q + 7'd1;

  bcd_dabble_step u_step (
    .scratch_i (scratch_q),
    .scratch_o (scratch_d)
  );

  // Value loaded into bcd on the final iteration.
  always_comb begin
`ifdef RESULT_BCD_BLANK_EN
    bcd_d = blank_leading(scratch_d[SCRATCH_W-1:RESULT_W]);
`else
    bcd_d = scratch_d[SCRATCH_W-1:RESULT_W];
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rv_q        <= 1'b0;
      scratch_q   <= '0;
      cnt_q       <= '0;
      bcd_q       <= '0;
      bcd_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (enable) begin
      // Edge detector tracks the input in every state, so an edge arriving
      // during SHIFT is consumed without starting anything.
      rv_q <= results_valid;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            scratch_q   <= {{BCD_W{1'b0}}, results};
            cnt_q       <= '0;
            bcd_valid_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= SHIFT;
          end
        end
        SHIFT: begin
          scratch_q <= scratch_d;
          cnt_q     <= cnt_d;
          if (cnt_d == CNT_W'(RESULT_W)) begin
            bcd_q       <= bcd_d;
            bcd_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= DONE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign bcd_valid = bcd_valid_q;
  assign bcd       = bcd_q;

endmodule

// File: tb/tb_result_bcd_conv.sv
module tb_result_bcd_conv;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        results_valid;
  logic [63:0] results;
  logic        busy;
  logic        bcd_valid;
  logic [79:0] bcd;

  int checks   = 0;
  int failures = 0;

  result_bcd_conv dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .results_valid (results_valid),
    .results       (results),
    .busy          (busy),
    .bcd_valid     (bcd_valid),
    .bcd           (bcd)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All driving and sampling happens 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // Leading-zero blanking: keep digits up to the most significant non-zero one.
  function automatic logic [79:0] tb_blank(input logic [79:0] r);
    logic [79:0] o;
    int          top;
    o   = r;
    top = 0;
    for (int i = 0; i < 20; i++) if (r[i*4 +: 4] != 4'h0) top = i;
    for (int i = top + 1; i < 20; i++) o[i*4 +: 4] = 4'hF;
    return o;
  endfunction

  function automatic logic [79:0] shown(input logic [79:0] plain);
`ifdef RESULT_BCD_BLANK_EN
    return tb_blank(plain);
`else
    return plain;
`endif
  endfunction

  // Decimal digits by repeated division.
  function automatic logic [79:0] ref_bcd(input logic [63:0] v);
    logic [79:0] r;
    logic [63:0] x;
    r = '0;
    x = v;
    for (int i = 0; i < 20; i++) begin
      r[i*4 +: 4] = 4'(x % 64'd10);
      x = x / 64'd10;
    end
    return shown(r);
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Run one conversion. Enable is dropped for gap_len cycles starting gap_start
  // cycles after capture. Checks busy at capture, busy during the run, latency,
  // value and busy after completion.
  task automatic run_conv(input string name, input logic [63:0] v, input logic [79:0] exp,
                          input int gap_start, input int gap_len);
    int   c;
    logic busy_bad;
    results       = v;
    results_valid = 1'b1;
    enable        = 1'b1;
    tick(); // E0
    chk({name, " busy@capture"}, 80'(busy), 80'd1);
    chk({name, " valid@capture"}, 80'(bcd_valid), 80'd0);
    c        = 0;
    busy_bad = 1'b0;
    while (c < 400) begin
      enable = !((c >= gap_start) && (c < gap_start + gap_len));
      tick();
      c++;
      if (bcd_valid) break;
      if (!busy) busy_bad = 1'b1;
    end
    enable = 1'b1;
    chk({name, " latency"}, 80'(c), 80'(64 + gap_len));
    chk({name, " busy_during"}, 80'(busy_bad), 80'd0);
    chk({name, " bcd"}, bcd, exp);
    chk({name, " busy_after"}, 80'(busy), 80'd0);
    results_valid = 1'b0;
    tick();
  endtask

  typedef struct {
    logic [63:0] val;
    logic [79:0] exp_plain;
    string       name;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [79:0] prev;
    logic [63:0] v;
    int          rises;
    int          busy_cycles;
    logic        last_busy;

    reset = 1'b1; enable = 1'b1; results_valid = 1'b0; results = '0;
    tick(); tick();
    chk("reset busy", 80'(busy), 80'd0);
    chk("reset bcd_valid", 80'(bcd_valid), 80'd0);
    chk("reset bcd", bcd, 80'h0);
    reset = 1'b0;
    tick();

    // ---- directed table ----
    vecs[0] = '{64'd0,                   80'h0,                          "zero"};
    vecs[1] = '{64'd6857,                80'h0000_0000_0000_0000_6857,   "v6857"};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 80'h1844_6744_0737_0955_1615,   "max"};
    vecs[3] = '{64'd600851475143,        80'h0000_0000_6008_5147_5143,   "v600851475143"};
    for (int i = 0; i < 4; i++) begin
      run_conv(vecs[i].name, vecs[i].val, shown(vecs[i].exp_plain), -1, 0);
    end

    // ---- restart from DONE: bcd keeps old value, bcd_valid drops ----
    prev          = bcd;
    results       = 64'd12345;
    results_valid = 1'b1;
    tick();
    chk("restart keeps bcd", bcd, prev);
    chk("restart clears valid", 80'(bcd_valid), 80'd0);
    // rising edge during SHIFT must be ignored
    for (int i = 0; i < 10; i++) tick();
    results_valid = 1'b0; tick();
    results_valid = 1'b1; tick();
    for (int i = 0; i < 60; i++) tick();
    chk("ignored edge valid", 80'(bcd_valid), 80'd1);
    chk("ignored edge value", bcd, ref_bcd(64'd12345));
    tick(); tick();
    chk("ignored edge no retrigger", 80'(busy), 80'd0);
    results_valid = 1'b0; tick();

    // ---- level held 300 cycles: one conversion only ----
    results       = 64'd987654321;
    results_valid = 1'b1;
    rises = 0; busy_cycles = 0; last_busy = busy;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (busy && !last_busy) rises++;
      if (busy) busy_cycles++;
      last_busy = busy;
    end
    chk("held busy pulses", 80'(rises), 80'd1);
    chk("held busy cycles", 80'(busy_cycles), 80'd64);
    chk("held value", bcd, ref_bcd(64'd987654321));
    results_valid = 1'b0; tick();

    // ---- enable low for 10 cycles during SHIFT ----
    run_conv("gap10", 64'd31415926535, ref_bcd(64'd31415926535), 20, 10);

    // ---- reset at iteration 30 ----
    results = 64'd4242424242; results_valid = 1'b1;
    tick();
    for (int i = 0; i < 30; i++) tick();
    reset = 1'b1;
    tick();
    chk("midreset busy", 80'(busy), 80'd0);
    chk("midreset valid", 80'(bcd_valid), 80'd0);
    chk("midreset bcd", bcd, 80'h0);
    // reset wins over a simultaneous start
    results_valid = 1'b0; tick();
    results_valid = 1'b1; tick();
    chk("reset beats start", 80'(busy), 80'd0);
    reset = 1'b0; results_valid = 1'b0; tick();
    run_conv("post_reset", 64'd600851475143, shown(80'h0000_0000_6008_5147_5143), -1, 0);

    // ---- randomized conversions with random enable gaps ----
    for (int k = 0; k < 16; k++) begin
      v = {$urandom, $urandom};
      v = v >> $urandom_range(0, 63);
      run_conv($sformatf("rand%0d", k), v, ref_bcd(v),
               int'($urandom_range(0, 63)), int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
